// File: rtl/hpdcache_sram_arb.sv
// -----------------------------------------------------------------------------
// hpdcache_sram_arb
//
// Round-robin arbiter that shares one single-port 1RW SRAM macro (1-cycle
// read latency) between NREQ requesters. After reset, or on a reinit pulse
// while running, the whole array is first zero-filled, one word per cycle.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   reinit       pulse in RUN: arbitrate this cycle, then restart zero-fill
//   init_done    1 while requests are accepted (state RUN)
//   req_valid    per-requester request valid
//   req_ready    per-requester grant (one-hot or zero), combinational
//   req_we       per-requester write enable
//   req_addr     packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
//   req_wdata    packed write data, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   rsp_valid    one-hot read-data valid, the cycle after a granted read
//   rsp_rdata    read data shared by all requesters (SRAM pass-through)
//   sram_*       SRAM macro interface (cs/we/addr/wdata/rdata)
// -----------------------------------------------------------------------------
module hpdcache_sram_arb #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 2**ADDR_SIZE,
    parameter int NREQ      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reinit,
    output logic                      init_done,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NREQ*DATA_SIZE-1:0] req_wdata,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATA_SIZE-1:0]      rsp_rdata,
    output logic                      sram_cs,
    output logic                      sram_we,
    output logic [ADDR_SIZE-1:0]      sram_addr,
    output logic [DATA_SIZE-1:0]      sram_wdata,
    input  logic [DATA_SIZE-1:0]      sram_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
    localparam logic [PTR_W-1:0]     LAST_REQ  = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0]      ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    logic [ADDR_SIZE-1:0] cnt_r;
    logic [PTR_W-1:0]     rr_r;
    logic [NREQ-1:0]      rsp_valid_r;
    logic                 init_done_r;

    logic                 run_s;
    logic                 any_valid_s;
    logic [PTR_W-1:0]     winner_s;
    logic [NREQ-1:0]      winner_oh_s;
    logic [NREQ-1:0]      rsp_next_s;

    assign run_s       = (state_r == ST_RUN);
    assign winner_oh_s = ONE_HOT0 << winner_s;

    // Round-robin search: first valid requester at or above rr_r, wrapping.
    // With nobody valid the winner defaults to requester 0 so the SRAM
    // address/data mux shows requester 0.
    always_comb begin : rr_search
        int idx;
        winner_s    = '0;
        any_valid_s = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!any_valid_s && req_valid[idx]) begin
                any_valid_s = 1'b1;
                winner_s    = PTR_W'(idx);
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // Grant and next read-response vector (reads only, RUN only).
    always_comb begin
        req_ready  = '0;
        rsp_next_s = '0;
        if (run_s && any_valid_s) begin
            req_ready = winner_oh_s;
            if (!req_we[winner_s]) begin
                rsp_next_s = winner_oh_s;
            end else begin
                rsp_next_s = '0;
            end
        end else begin
            req_ready  = '0;
            rsp_next_s = '0;
        end
    end

    // SRAM port mux: zero-fill sequencer in INIT, arbitration winner in RUN.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!run_s) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = cnt_r;
            sram_wdata = '0;
        end else begin
            sram_cs    = any_valid_s;
            sram_we    = any_valid_s & req_we[winner_s];
            sram_addr  = req_addr[int'(winner_s)*ADDR_SIZE +: ADDR_SIZE];
            sram_wdata = req_wdata[int'(winner_s)*DATA_SIZE +: DATA_SIZE];
        end
    end

    // State, fill counter, round-robin pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            rr_r        <= '0;
            rsp_valid_r <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rsp_valid_r <= '0;
                    if (cnt_r == LAST_ADDR) begin
                        cnt_r       <= '0;
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r       <= cnt_r + ADDR_SIZE'(1);
                    end
                end
                ST_RUN: begin
                    // A read granted in a reinit cycle still returns its data.
                    rsp_valid_r <= rsp_next_s;
                    if (any_valid_s) begin
                        rr_r <= (winner_s == LAST_REQ) ? '0 : winner_s + PTR_W'(1);
                    end else begin
                        rr_r <= rr_r;
                    end
                    if (reinit) begin
                        state_r     <= ST_INIT;
                        cnt_r       <= '0;
                        init_done_r <= 1'b0;
                    end else begin
                        state_r     <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    rsp_valid_r <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign init_done = init_done_r;
    assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_hpdcache_sram_arb.sv
module tb_hpdcache_sram_arb;

    localparam int AW = 6;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          reinit;
    logic          init_done;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    hpdcache_sram_arb #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM with one-cycle read latency.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    oh;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every response must match the head of the scoreboard
    // in the exact cycle it is due; a due entry with no response is a miss.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {126'd0, rsp_valid}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", {126'd0, rsp_valid}, {126'd0, e.oh});
                chk("rsp_rdata", {64'd0, rsp_rdata}, {64'd0, e.data});
                chk("rsp_cycle", 128'(cyc), 128'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("missing_rsp", 128'(cyc), 128'(sb[0].due + 1000));
            void'(sb.pop_front());
        end
    end

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        reinit    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle, check the grant, record the expected response.
    task automatic issue(input string name, input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                         input logic ri, input logic [1:0] exp_rdy,
                         input logic [DW-1:0] exp_rd);
        exp_t e;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {wd1, wd0};
        reinit    = ri;
        #1;
        chk(name, {126'd0, req_ready}, {126'd0, exp_rdy});
        if ((exp_rdy & ~we) != 2'b00) begin
            e.oh   = exp_rdy;
            e.data = exp_rd;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        step();
        idle_inputs();
    endtask

    // Check n cycles of zero-fill starting from address 0.
    task automatic fill(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            chk($sformatf("fill%0d", c),
                {57'd0, sram_cs, sram_we, sram_addr, sram_wdata, req_ready, init_done},
                {57'd0, 1'b1, 1'b1, AW'(c), 64'd0, 2'b00, 1'b0});
            step();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_state", {122'd0, init_done, req_ready, rsp_valid, sram_cs},
            {122'd0, 1'b0, 2'b00, 2'b00, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full fill after reset, then init_done.
        fill(64);
        chk("init_done_after_fill", {127'd0, init_done}, 128'd1);

        // Write then read addr 5 via requester 0 (pointer ends at 1).
        issue("wr0_a5", 2'b01, 2'b01, 6'd5, 6'd0, 64'hDEAD_BEEF, 64'd0, 1'b0, 2'b01, 64'd0);
        issue("rd0_a5", 2'b01, 2'b00, 6'd5, 6'd0, 64'd0, 64'd0, 1'b0, 2'b01, 64'hDEAD_BEEF);

        // Requester 1 alone three times, then both: 1,1,1,0,1,0,1,0,1.
        for (int i = 0; i < 3; i++)
            issue("solo1", 2'b10, 2'b00, 6'd6, 6'd5, 64'd0, 64'd0, 1'b0, 2'b10, 64'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) begin
            logic [1:0] r;
            r = (i % 2 == 0) ? 2'b01 : 2'b10;
            issue($sformatf("both%0d", i), 2'b11, 2'b00, 6'd6, 6'd5, 64'd0, 64'd0, 1'b0,
                  r, (i % 2 == 0) ? 64'd0 : 64'hDEAD_BEEF);
        end

        // Requester 1 writes 0x1234 at addr 7, then reads it alongside reinit.
        issue("wr1_a7", 2'b10, 2'b10, 6'd0, 6'd7, 64'd0, 64'h1234, 1'b0, 2'b10, 64'd0);
        issue("rd1_a7_reinit", 2'b10, 2'b00, 6'd0, 6'd7, 64'd0, 64'd0, 1'b1, 2'b10, 64'h1234);
        fill(64);
        chk("init_done_after_reinit", {127'd0, init_done}, 128'd1);
        issue("rd0_a7_zero", 2'b01, 2'b00, 6'd7, 6'd0, 64'd0, 64'd0, 1'b0, 2'b01, 64'd0);
        step();

        // Reinit with no requests, then reset in the middle of the fill.
        issue("reinit_idle", 2'b00, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0, 1'b1, 2'b00, 64'd0);
        fill(20);
        chk("addr_at_20", {122'd0, sram_addr}, 128'd20);
        rst_n = 1'b0;
        #1;
        chk("midfill_reset", {120'd0, sram_addr, init_done, rsp_valid},
            {120'd0, 6'd0, 1'b0, 2'b00});
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill(64);
        chk("init_done_after_rst", {127'd0, init_done}, 128'd1);
        issue("rd1_a5_final", 2'b10, 2'b00, 6'd0, 6'd5, 64'd0, 64'd0, 1'b0, 2'b01 << 1, 64'd0);
        step();
        step();
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpdcache_sram_arb.md
Name: hpdcache_sram_arb

Overview:
- Arbitrates one single-port 1RW SRAM macro (cs/we/addr/wdata/rdata, 1-cycle read latency) between NREQ requesters using round-robin.
- After reset, or on an explicit reinit request, it first sequences a zero-fill of every entry.
- Sits between cache sub-blocks (e.g. refill, core access, flush) and the shared directory/data RAM instance.

Parameters:
- ADDR_SIZE, 6, SRAM address width.
- DATA_SIZE, 64, SRAM word width.
- DEPTH, 2**ADDR_SIZE, number of entries; legal range 1..2**ADDR_SIZE.
- NREQ, 2, number of requesters; legal range >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- reinit  input  1  pulse: restart zero-fill (honoured only when not already initialising)
- init_done  output  1  1 when zero-fill is complete and requests are accepted
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant (one-hot or zero)
- req_we  input  NREQ  per-requester write enable
- req_addr  input  NREQ*ADDR_SIZE  flattened addresses; requester i occupies [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  input  NREQ*DATA_SIZE  flattened write data, same packing
- rsp_valid  output  NREQ  one-hot read-data valid
- rsp_rdata  output  DATA_SIZE  read data, shared by all requesters
- sram_cs  output  1  SRAM chip select
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_SIZE  SRAM address
- sram_wdata  output  DATA_SIZE  SRAM write data (full-word write)
- sram_rdata  input  DATA_SIZE  SRAM read data, valid the cycle after a read cs

Behaviour:
- Reset values (asynchronous):
  - state=INIT, init counter=0, rr pointer=0 (requester 0 highest priority), rsp_valid=0, init_done=0.
  - Consequently req_ready=0. The outputs sram_* are driven per INIT state immediately.
- INIT state:
  - Each cycle: sram_cs=1, sram_we=1, sram_addr=counter, sram_wdata=0; req_ready=0.
  - Counter increments each cycle.
  - When counter==DEPTH-1, the write at DEPTH-1 occurs that cycle, the counter clears to 0, and state becomes RUN.
  - Fill therefore takes exactly DEPTH cycles. No address beyond DEPTH-1 is ever written.
  - reinit is ignored in INIT.
- RUN state:
  - init_done=1 (registered; equivalent to state==RUN).
  - Grant is combinational:
    - The first valid requester at or after the rr pointer, searching upward with wrap-around, wins.
    - req_ready is one-hot for the winner and 0 elsewhere; it is independent of the valid signal of non-winners.
  - sram_cs = any req_valid. sram_we, sram_addr and sram_wdata are muxed from the winner.
  - When sram_cs=0, sram_we=0 and sram_addr/sram_wdata hold the muxed value of requester 0 (don't-care).
  - On each grant, rr pointer <= winner+1, wrapping NREQ-1 -> 0. With no grant, the pointer holds.
  - Requesters must hold valid and payload until granted. The block does not check this.
- Read response:
  - A granted read (we=0) in cycle t gives rsp_valid[winner]=1 in t+1, with rsp_rdata=sram_rdata (pass-through).
  - rsp_valid is registered; no response backpressure exists. Writes produce no response.
  - Back-to-back reads from any mix of requesters are allowed every cycle, with full throughput.
- reinit asserted in RUN:
  - The same cycle is still arbitrated normally.
  - Next cycle: state=INIT, counter=0, init_done=0, rr pointer kept.
  - A read granted in the reinit cycle still returns rsp_valid/rsp_rdata in the following cycle, while zero-fill writes begin.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values. A pending rsp_valid is dropped.
- DEPTH=1: INIT lasts one cycle, writing address 0.

Test Plan:
- Reset then idle, DEPTH=64: sram writes with addr 0..63 and wdata=0 on 64 consecutive cycles; init_done rises on cycle 65; no req_ready during fill.
- After init, requester 0 writes addr 5 with 0xDEAD_BEEF, then reads addr 5: rsp_valid=2'b01 one cycle after the read grant, rsp_rdata=0xDEAD_BEEF; the write gives no rsp_valid.
- Both requesters continuously valid with reads, NREQ=2: grants alternate 0,1,0,1 starting with 0; rsp_valid alternates one cycle later; 1 grant per cycle.
- Requester 1 is the only one valid for 3 cycles, then both valid: grants go 1,1,1, then 0 (pointer wrapped to 0), then 1.
- Requester 1 reads addr 7 (holding 0x1234) in the same cycle reinit=1: rsp_valid=2'b10 with 0x1234 next cycle; zero-fill restarts at addr 0 that cycle; a subsequent read of addr 7 after init_done returns 0.
- rst_n dropped mid-fill at counter=20: outputs reset immediately; after release the fill restarts from addr 0 and takes the full 64 cycles.
